fp_decode_serial: RTL and testbench

Sequential decoder that expands the team's 8-bit compressed floating-point format (sign S, 3-bit exponent E, 4-bit significand F) back into a 12-bit two's-complement linear sample D. It sits on the receive side, opposite the linear-to-float encoder, and reconstructs D = (−1)^S · (F << E). The shift is performed one bit per clock, and the block uses valid/ready handshakes on both the input and output sides.

---
 rtl/fp_decode_serial.sv | 97 +++++++++
 tb/tb_fp_decode_serial.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fp_decode_serial.sv
// fp_decode_serial
//   Expands an 8-bit compressed float {S, E[2:0], F[3:0]} into a 12-bit
//   two's-complement sample D = (-1)^S * (F << E). The shift is done one bit
//   per clock. Valid/ready handshakes are used on both the input and output.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   S, E, F    incoming float fields (sign, exponent 0-7, significand 0-15)
//   in_valid   S/E/F valid this cycle
//   in_ready   block can accept a float this cycle (IDLE and not in reset)
//   D          decoded sample, held while out_valid is high
//   out_valid  D holds a completed result
//   out_ready  downstream consumes D this cycle
module fp_decode_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        S,
  input  logic [2:0]  E,
  input  logic [3:0]  F,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] D,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, HOLD} state_t;

  state_t      state_q, state_d;
  logic [11:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        s_q, s_d;
  logic [11:0] d_d;
  logic        ov_d;

  assign in_ready = (state_q == IDLE) & ~rst;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    d_d     = D;
    ov_d    = out_valid;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          acc_d   = {8'b0, F};
          cnt_d   = E;
          s_d     = S;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 3'd0) begin
          acc_d = acc_q << 1;
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        // Negating zero wraps back to zero, so there is no negative zero.
        d_d     = s_q ? (~acc_q + 12'd1) : acc_q;
        ov_d    = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      s_q       <= 1'b0;
      D         <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      D         <= d_d;
      out_valid <= ov_d;
    end
  end

endmodule

// File: tb/tb_fp_decode_serial.sv
// Directed bench for fp_decode_serial: reset behaviour, latency, sign and
// zero cases, backpressure, mid-conversion reset, and a sweep of all 256
// input codes against a (-1)^S*(F<<E) reference.
module tb_fp_decode_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] D;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_decode_serial dut (
    .clk       (clk),
    .rst       (rst),
    .S         (S),
    .E         (E),
    .F         (F),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Presents one float in IDLE, scrambles the inputs after acceptance, and
  // returns the number of edges from the accept edge until out_valid rises.
  task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f, output int lat);
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    S = s; E = e; F = f; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    S = ~s; E = ~e; F = ~f;
    lat = 0;
    while (!out_valid && lat <= 20) begin
      step;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ov_seen;
    int mag;
    logic [11:0] exp_d;
    logic       s;
    logic [2:0] e;
    logic [3:0] f;

    rst = 1'b1; S = 1'b0; E = '0; F = '0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset
    step;
    step;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_D", {20'b0, D}, 32'h000);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);
    step;
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);

    // Maximum magnitude, maximum latency
    out_ready = 1'b1;
    send(1'b0, 3'd7, 4'd15, lat);
    check("max_lat", lat, 32'd9);
    check("max_D", {20'b0, D}, 32'h780);
    step;
    check("max_ov_fall", {31'b0, out_valid}, 32'd0);
    check("max_in_ready_back", {31'b0, in_ready}, 32'd1);

    // -1 with minimum latency, then negative-sign zero
    send(1'b1, 3'd0, 4'd1, lat);
    check("neg1_lat", lat, 32'd2);
    check("neg1_D", {20'b0, D}, 32'hFFF);
    step;
    send(1'b1, 3'd5, 4'd0, lat);
    check("zero_lat", lat, 32'd7);
    check("zero_D", {20'b0, D}, 32'h000);
    step;

    // Backpressure with an ignored input pulse during HOLD
    out_ready = 1'b0;
    send(1'b1, 3'd3, 4'd9, lat);
    check("bp_lat", lat, 32'd5);
    check("bp_D", {20'b0, D}, 32'hFB8);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; S = 1'b0; E = 3'd0; F = 4'd5;
      end else begin
        in_valid = 1'b0;
      end
      step;
      check("bp_D_hold", {20'b0, D}, 32'hFB8);
      check("bp_ov_hold", {31'b0, out_valid}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    check("bp_ov_fall", {31'b0, out_valid}, 32'd0);
    check("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
    step;
    check("bp_pulse_not_queued", {31'b0, out_valid}, 32'd0);

    // Reset during SHIFT discards the pending sample
    S = 1'b0; E = 3'd6; F = 4'd10; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;
    check("midrst_ov", {31'b0, out_valid}, 32'd0);
    check("midrst_D", {20'b0, D}, 32'h000);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (out_valid) ov_seen++;
    end
    check("midrst_no_output", ov_seen, 32'd0);
    send(1'b0, 3'd2, 4'd3, lat);
    check("after_rst_lat", lat, 32'd4);
    check("after_rst_D", {20'b0, D}, 32'h00C);
    step;

    // All 256 codes back to back
    for (int i = 0; i < 256; i++) begin
      s = (i >= 128);
      e = 3'((i / 16) % 8);
      f = 4'(i % 16);
      mag = int'(f) << e;
      exp_d = s ? 12'(-mag) : 12'(mag);
      send(s, e, f, lat);
      check($sformatf("sweep_lat_%0d", i), lat, 32'(e) + 32'd2);
      check($sformatf("sweep_D_%0d", i), {20'b0, D}, {20'b0, exp_d});
      step;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
